fb_particle_plotter: RTL and testbench

- Writer side of the 1-bit display framebuffer: produces the write address and data that the VGA scan-out path reads from its dual-port BRAM.
- On each start pulse it clears the whole frame to 0, then reads every particle position from the particle memory and writes a 1 at each particle's pixel.
- Sits between the fluid-simulation core and the framebuffer write port, all on the system clock clk.

---
 rtl/fb_plot_if.sv | 35 +++
 rtl/fb_particle_plotter.sv | 163 ++++++++++++++++
 tb/tb_fb_particle_plotter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fb_plot_if.sv
// Bus between the fluid-sim side and the framebuffer plotter.
// Carries the frame control (start/busy/done), the particle memory read
// port, the framebuffer write port and the per-frame clip statistic.
//   master : frame controller / particle memory side
//   slave  : fb_particle_plotter
interface fb_plot_if #(
  parameter int DRAW_ADDRW = 17,
  parameter int DRAW_DATAW = 1,
  parameter int PADDRW     = 8,
  parameter int COORDW     = 16,
  parameter int CNTW       = 9
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [PADDRW-1:0]     particle_addr;
  logic [COORDW-1:0]     particle_x;
  logic [COORDW-1:0]     particle_y;
  logic                  draw_we;
  logic [DRAW_ADDRW-1:0] draw_addr_write;
  logic [DRAW_DATAW-1:0] draw_data_in;
  logic [CNTW-1:0]       clipped_count;

  modport master (
    output start, particle_x, particle_y,
    input  busy, done, particle_addr, draw_we, draw_addr_write,
           draw_data_in, clipped_count
  );

  modport slave (
    input  start, particle_x, particle_y,
    output busy, done, particle_addr, draw_we, draw_addr_write,
           draw_data_in, clipped_count
  );
endinterface

// File: rtl/fb_particle_plotter.sv
// Writer side of the 1-bit display framebuffer.
// On start: clears every framebuffer word to 0 (one per cycle), then reads
// each particle position (1-cycle read latency) and writes a 1 at its pixel.
// Off-screen particles are skipped and counted in clipped_count.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : fb_plot_if slave (start/busy/done, particle read port,
//              framebuffer write port, clipped_count); all outputs registered
//
// state  | meaning
// IDLE   | waiting for start (ignored while done is showing)
// CLEAR  | writing 0 to addresses 0..DRAW_SIZE-1
// PLOT   | issuing particle reads and writing on-screen pixels
// FINISH | last plot slot on the bus; raises done next cycle
module fb_particle_plotter #(
  parameter int DRAW_WIDTH     = 320,
  parameter int DRAW_HEIGHT    = 240,
  parameter int DRAW_SIZE      = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int DRAW_ADDRW     = $clog2(DRAW_SIZE),
  parameter int DRAW_DATAW     = 1,
  parameter int PARTICLE_COUNT = 256,
  parameter int PADDRW         = $clog2(PARTICLE_COUNT),
  parameter int COORDW         = 16,
  parameter int FRAC_BITS      = 4
) (
  input logic    clk,
  input logic    rst,
  fb_plot_if.slave bus
);

  localparam int CNTW = $clog2(PARTICLE_COUNT + 1);
  // Wide enough for py*DRAW_WIDTH+px with any coordinate value.
  localparam int PW   = COORDW + $clog2(DRAW_WIDTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, PLOT, FINISH} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PADDRW-1:0]     particle_addr_q, particle_addr_d;
  logic                  draw_we_q, draw_we_d;
  logic [DRAW_ADDRW-1:0] draw_addr_write_q, draw_addr_write_d;
  logic [DRAW_DATAW-1:0] draw_data_in_q, draw_data_in_d;
  logic [CNTW-1:0]       clipped_count_q, clipped_count_d;
  // rd_vld: particle_x/y carry a requested particle this cycle.
  // last_issued: the read for particle N-1 has been presented.
  logic                  rd_vld_q, rd_vld_d;
  logic                  last_issued_q, last_issued_d;

  logic [PW-1:0] px_w, py_w, pix_addr_w;
  logic          on_screen;

  always_comb begin
    px_w       = PW'(bus.particle_x >> FRAC_BITS);
    py_w       = PW'(bus.particle_y >> FRAC_BITS);
    on_screen  = (px_w < PW'(DRAW_WIDTH)) && (py_w < PW'(DRAW_HEIGHT));
    pix_addr_w = py_w * PW'(DRAW_WIDTH) + px_w;
  end

  always_comb begin
    state_d           = state_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    particle_addr_d   = particle_addr_q;
    draw_we_d         = 1'b0;
    draw_addr_write_d = draw_addr_write_q;
    draw_data_in_d    = '0;
    clipped_count_d   = clipped_count_q;
    rd_vld_d          = 1'b0;
    last_issued_d     = last_issued_q;

    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, where start must be ignored.
        if (bus.start && !done_q) begin
          state_d           = CLEAR;
          busy_d            = 1'b1;
          draw_we_d         = 1'b1;
          draw_addr_write_d = '0;
          clipped_count_d   = '0;
          particle_addr_d   = '0;
          last_issued_d     = 1'b0;
        end
      end

      CLEAR: begin
        if (draw_addr_write_q == DRAW_ADDRW'(DRAW_SIZE - 1)) begin
          state_d = PLOT;
        end else begin
          draw_we_d         = 1'b1;
          draw_addr_write_d = draw_addr_write_q + DRAW_ADDRW'(1);
        end
      end

      PLOT: begin
        if (rd_vld_q) begin
          if (on_screen) begin
            draw_we_d         = 1'b1;
            draw_addr_write_d = pix_addr_w[DRAW_ADDRW-1:0];
            draw_data_in_d    = {DRAW_DATAW{1'b1}};
          end else if (clipped_count_q != CNTW'(PARTICLE_COUNT)) begin
            clipped_count_d = clipped_count_q + CNTW'(1);
          end
        end
        if (!last_issued_q) begin
          rd_vld_d = 1'b1;
          if (particle_addr_q == PADDRW'(PARTICLE_COUNT - 1)) begin
            last_issued_d   = 1'b1;
            particle_addr_d = '0;
          end else begin
            particle_addr_d = particle_addr_q + PADDRW'(1);
          end
        end else begin
          // This cycle carries the last particle's data; its slot is next.
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      particle_addr_q   <= '0;
      draw_we_q         <= 1'b0;
      draw_addr_write_q <= '0;
      draw_data_in_q    <= '0;
      clipped_count_q   <= '0;
      rd_vld_q          <= 1'b0;
      last_issued_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      particle_addr_q   <= particle_addr_d;
      draw_we_q         <= draw_we_d;
      draw_addr_write_q <= draw_addr_write_d;
      draw_data_in_q    <= draw_data_in_d;
      clipped_count_q   <= clipped_count_d;
      rd_vld_q          <= rd_vld_d;
      last_issued_q     <= last_issued_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.particle_addr   = particle_addr_q;
  assign bus.draw_we         = draw_we_q;
  assign bus.draw_addr_write = draw_addr_write_q;
  assign bus.draw_data_in    = draw_data_in_q;
  assign bus.clipped_count   = clipped_count_q;

endmodule

// File: tb/tb_fb_particle_plotter.sv
// Scoreboard bench for fb_particle_plotter on a reduced 20x12 frame with
// 16 particles, so several complete frames fit in a short run.
module tb_fb_particle_plotter;
  localparam int W   = 20;
  localparam int H   = 12;
  localparam int S   = W * H;
  localparam int AW  = $clog2(S);
  localparam int DW  = 1;
  localparam int N   = 16;
  localparam int PAW = $clog2(N);
  localparam int CW  = 16;
  localparam int FB  = 4;
  localparam int CCW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_plot_if #(.DRAW_ADDRW(AW), .DRAW_DATAW(DW), .PADDRW(PAW), .COORDW(CW), .CNTW(CCW)) bus();

  fb_particle_plotter #(
    .DRAW_WIDTH(W), .DRAW_HEIGHT(H), .DRAW_SIZE(S), .DRAW_ADDRW(AW), .DRAW_DATAW(DW),
    .PARTICLE_COUNT(N), .PADDRW(PAW), .COORDW(CW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Particle memory with 1-cycle synchronous read.
  logic [CW-1:0] xm [N];
  logic [CW-1:0] ym [N];
  always @(posedge clk) begin
    bus.particle_x <= xm[bus.particle_addr];
    bus.particle_y <= ym[bus.particle_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int d; } wr_t;
  typedef struct { int c; int clip; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int busy_lo = 1, busy_hi = 0, pa_lo = 1, pa_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pix(input logic [CW-1:0] x, input logic [CW-1:0] y);
    int px, py;
    px = int'(x >> FB);
    py = int'(y >> FB);
    if (px >= W || py >= H) return -1;
    return py * W + px;
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a write or done.
  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (mon_en) begin
      chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (cyc >= pa_lo && cyc <= pa_hi)
        chk("particle_addr", 32'(bus.particle_addr), cyc - pa_lo);
      if (bus.draw_we !== 1'b0) begin
        if (wq.size() == 0) begin
          chk("unexpected_we", 32'(bus.draw_we), 0);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", cyc, w.c);
          chk("wr_addr", 32'(bus.draw_addr_write), w.a);
          chk("wr_data", 32'(bus.draw_data_in), w.d);
        end
      end
      if (bus.done !== 1'b0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 0);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d.c);
          chk("done_clipped", 32'(bus.clipped_count), d.clip);
        end
      end
    end
  end

  // rst_at: frame cycle in which rst is raised (0 = none).
  // extra: frame cycle of a spurious start; also pulses start in the done cycle.
  task automatic run_frame(input int rst_at, input int extra);
    int c0, lim, clip, a;
    @(negedge clk);
    c0   = cyc + 1;
    lim  = (rst_at > 0) ? rst_at : S + N + 2;
    clip = 0;
    for (int k = 1; k <= S; k++)
      if (k <= lim) wq.push_back('{c0 + k - 1, k - 1, 0});
    for (int i = 0; i < N; i++) begin
      a = pix(xm[i], ym[i]);
      if (a < 0) clip++;
      else if (S + 3 + i <= lim) wq.push_back('{c0 + S + 2 + i, a, 1});
    end
    if (rst_at == 0) dq.push_back('{c0 + S + N + 2, clip});
    busy_lo = c0;
    busy_hi = c0 + lim - 1;
    pa_lo   = c0 + S;
    pa_hi   = (c0 + S + N - 1 < busy_hi) ? c0 + S + N - 1 : busy_hi;
    bus.start = 1'b1;
    for (int k = 1; k <= S + N + 4; k++) begin
      @(negedge clk);
      bus.start = (extra > 0) && (k == extra || k == S + N + 3);
      rst = (k == rst_at);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("writes_outstanding", wq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
    if (rst_at > 0) chk("clipped_after_rst", 32'(bus.clipped_count), 0);
    else            chk("clipped_final", 32'(bus.clipped_count), clip);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin xm[i] = '0; ym[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_we", 32'(bus.draw_we), 0);
      chk("idle_done", 32'(bus.done), 0);
      chk("idle_clipped", 32'(bus.clipped_count), 0);
    end

    // All particles at pixel (10,5) -> address 110.
    for (int i = 0; i < N; i++) begin xm[i] = 16'd160; ym[i] = 16'd80; end
    run_frame(0, 0);

    // Corner pixel (19,11) -> address 239, plus three off-screen particles.
    xm[0] = 16'd319;    ym[0] = 16'd191;
    xm[1] = 16'd320;    ym[1] = 16'd0;
    xm[2] = 16'd0;      ym[2] = 16'd192;
    xm[3] = 16'hFFFF;   ym[3] = 16'hFFFF;
    for (int i = 4; i < N; i++) begin
      xm[i] = CW'(i * 16 + 3);
      ym[i] = CW'((i % 12) * 16 + 15);
    end
    run_frame(0, 0);

    // Particle i at pixel (i,0); spurious starts mid-clear and in done cycle.
    for (int i = 0; i < N; i++) begin xm[i] = CW'(i << 4); ym[i] = '0; end
    run_frame(0, 100);

    // All off-screen: clipped_count reaches N.
    for (int i = 0; i < N; i++) begin xm[i] = 16'hFFFF; ym[i] = CW'(i); end
    run_frame(0, 0);

    // Reset during PLOT, then a fresh complete frame.
    for (int i = 0; i < N; i++) begin xm[i] = CW'(i << 4); ym[i] = CW'(i << 3); end
    run_frame(S + 5, 0);
    run_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
